// File: rtl/seg16_scroll_decoder.sv
// seg16_scroll_decoder: watches a 4-digit scrolling 16-segment display, detects
// one-position left scrolls and queues the decoded incoming glyph as ASCII.
module seg16_scroll_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   seg_a,
  input  logic [15:0]                   seg_b,
  input  logic [15:0]                   seg_c,
  input  logic [15:0]                   seg_d,
  output logic [7:0]                    ch_data,
  output logic                          ch_unknown,
  output logic                          ch_valid,
  input  logic                          ch_ready,
  output logic                          shift_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {WAIT_CHANGE, SETTLE, CLASSIFY} state_t;
  state_t state, state_n;
  logic [63:0] samp, f, k, k_n;
  logic [7:0] cnt, cnt_n;
  logic scroll_ok, push, pop, full, accept;
  logic [8:0] glyph;
  logic [8:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  function automatic logic [8:0] decode(input logic [15:0] p);
    case (p)
      16'hCF00: decode = {1'b0, 8'h43};
      16'h00FF: decode = {1'b0, 8'h4F};
      16'hFFD5: decode = {1'b0, 8'h59};
      16'hFFFF: decode = {1'b0, 8'h20};
      16'hF1BD: decode = {1'b0, 8'h61};
      16'hFDBD: decode = {1'b0, 8'h6E};
      16'hC77D: decode = {1'b0, 8'h64};
      16'h0C3F: decode = {1'b0, 8'h41};
      16'h1C3F: decode = {1'b0, 8'h50};
      16'hCCD7: decode = {1'b0, 8'h4D};
      16'hCC3F: decode = {1'b0, 8'h48};
      default:  decode = {1'b1, 8'h3F};
    endcase
  endfunction
  assign samp = {seg_a, seg_b, seg_c, seg_d};
  assign scroll_ok = k[63:16] == f[47:0];
  assign push = state == CLASSIFY && scroll_ok;
  assign glyph = decode(k[15:0]);
  always_comb begin
    state_n = state;
    k_n = k;
    cnt_n = cnt;
    case (state)
      WAIT_CHANGE: if (samp != f) begin
        k_n = samp;
        cnt_n = 8'd1;
        state_n = SETTLE;
      end
      SETTLE: if (samp != k) begin
        k_n = samp;
        cnt_n = 8'd1;
      end else begin
        cnt_n = cnt + 8'd1;
        // a glitch that settles back onto the current frame is not an event
        if (cnt_n == STABLE) state_n = (k == f) ? WAIT_CHANGE : CLASSIFY;
      end
      default: state_n = WAIT_CHANGE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_CHANGE;
      f <= '1;
      k <= '1;
      cnt <= '0;
      shift_err <= 1'b0;
    end else begin
      state <= state_n;
      k <= k_n;
      cnt <= cnt_n;
      shift_err <= state == CLASSIFY && !scroll_ok;
      if (state == CLASSIFY) f <= k;
    end
  end
  assign ch_valid = fifo_level != '0;
  assign pop = ch_valid && ch_ready;
  assign full = fifo_level == DEPTH;
  assign accept = push && (!full || pop);
  assign {ch_unknown, ch_data} = ch_valid ? mem[rp] : 9'd0;
  always_ff @(posedge clk) if (accept) mem[wp] <= glyph;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fifo_level <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      fifo_level <= fifo_level + (AW+1)'(accept) - (AW+1)'(pop);
      overflow <= overflow | (push && full && !pop);
    end
  end
endmodule

// File: tb/tb_seg16_scroll_decoder.sv
// tb_seg16_scroll_decoder: vector table, hand sequences and a random scroll
// scoreboard for the 16-segment scroll decoder.
module tb_seg16_scroll_decoder;
  logic clk = 0, rst = 1, ch_ready = 0;
  logic [15:0] seg_a, seg_b, seg_c, seg_d;
  logic [7:0] ch_data;
  logic ch_unknown, ch_valid, shift_err, overflow;
  logic [3:0] fifo_level;
  int n_chk = 0, n_fail = 0, err_cnt = 0, exp_err = 0;
  logic sb_on = 0;
  logic [8:0] sb_e;
  logic [8:0] exp_q[$];
  logic [63:0] cur, nf;
  logic [15:0] g;
  logic [7:0] dec[logic [15:0]];
  logic [15:0] known[11] = '{16'hCF00, 16'h00FF, 16'hFFD5, 16'hFFFF, 16'hF1BD, 16'hFDBD,
                            16'hC77D, 16'h0C3F, 16'h1C3F, 16'hCCD7, 16'hCC3F};
  typedef struct {logic [63:0] fr; logic push; logic [8:0] ch; logic err;} vec_t;
  vec_t tv[14];

  seg16_scroll_decoder dut (.clk(clk), .rst(rst), .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c),
    .seg_d(seg_d), .ch_data(ch_data), .ch_unknown(ch_unknown), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .shift_err(shift_err), .overflow(overflow), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic [63:0] fr);
    {seg_a, seg_b, seg_c, seg_d} = fr;
  endtask
  task automatic hold_rand(input int n);
    for (int i = 0; i < n; i++) begin
      ch_ready = $urandom_range(0, 3) != 0;
      step();
    end
  endtask
  function automatic logic [8:0] mdl(input logic [15:0] p);
    return dec.exists(p) ? {1'b0, dec[p]} : {1'b1, 8'h3F};
  endfunction

  always @(negedge clk) begin
    if (!rst) err_cnt += int'(shift_err);
    if (sb_on && ch_valid && ch_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pop", {ch_unknown, ch_data}, 9'h1FF);
      else begin
        sb_e = exp_q.pop_front();
        chk("sb_pop", {ch_unknown, ch_data}, sb_e);
      end
    end
  end

  initial begin
    dec[16'hCF00] = "C"; dec[16'h00FF] = "O"; dec[16'hFFD5] = "Y"; dec[16'hFFFF] = " ";
    dec[16'hF1BD] = "a"; dec[16'hFDBD] = "n"; dec[16'hC77D] = "d"; dec[16'h0C3F] = "A";
    dec[16'h1C3F] = "P"; dec[16'hCCD7] = "M"; dec[16'hCC3F] = "H";
    tv[0]  = '{64'hFFFF_FFFF_FFFF_CF00, 1, 9'h043, 0};
    tv[1]  = '{64'hFFFF_FFFF_CF00_00FF, 1, 9'h04F, 0};
    tv[2]  = '{64'hFFFF_CF00_00FF_FFD5, 1, 9'h059, 0};
    tv[3]  = '{64'hCF00_00FF_FFD5_FFFF, 1, 9'h020, 0};
    tv[4]  = '{64'h00FF_FFD5_FFFF_FFFF, 1, 9'h020, 0};
    tv[5]  = '{64'hFFD5_FFFF_FFFF_F1BD, 1, 9'h061, 0};
    tv[6]  = '{64'hFFFF_FFFF_F1BD_FDBD, 1, 9'h06E, 0};
    tv[7]  = '{64'hFFFF_F1BD_FDBD_C77D, 1, 9'h064, 0};
    tv[8]  = '{64'h0C3F_1C3F_0C3F_CC3F, 0, 9'h000, 1};
    tv[9]  = '{64'h1C3F_0C3F_CC3F_1234, 1, 9'h13F, 0};
    tv[10] = '{64'h0C3F_CC3F_1234_CCD7, 1, 9'h04D, 0};
    tv[11] = '{64'hCC3F_1234_CCD7_0C3F, 1, 9'h041, 0};
    tv[12] = '{64'h1234_CCD7_0C3F_1C3F, 1, 9'h050, 0};
    tv[13] = '{64'hCCD7_0C3F_1C3F_CC3F, 1, 9'h048, 0};

    drv('1);
    repeat (3) step();
    chk("rst_valid", ch_valid, 0);
    chk("rst_data", {ch_unknown, ch_data}, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_shift_err", shift_err, 0);
    rst = 0;

    drv(64'hFFFF_FFFF_FFFF_00FF);
    repeat (2) step();
    drv('1);
    repeat (8) step();
    chk("glitch_level", fifo_level, 0);
    chk("glitch_err", err_cnt, 0);

    foreach (tv[i]) begin
      drv(tv[i].fr);
      repeat (4) step();
      chk("pre_valid", ch_valid, 0);
      chk("pre_err", shift_err, 0);
      step();
      chk("push_valid", ch_valid, tv[i].push);
      chk("err_pulse", shift_err, tv[i].err);
      if (tv[i].push) chk("push_char", {ch_unknown, ch_data}, tv[i].ch);
      step();
      chk("err_clear", shift_err, 0);
      exp_err += int'(tv[i].err);
      if (tv[i].push) begin
        ch_ready = 1;
        step();
        ch_ready = 0;
        chk("pop_level", fifo_level, 0);
      end
    end
    chk("table_err_count", err_cnt, exp_err);

    cur = tv[13].fr;
    sb_on = 1;
    for (int it = 0; it < 80; it++) begin
      int r = $urandom_range(0, 9);
      if (r < 7) begin
        g = ($urandom_range(0, 3) == 0) ? 16'($urandom) : known[$urandom_range(0, 10)];
        nf = {cur[47:0], g};
        if (nf != cur) exp_q.push_back(mdl(g));
        cur = nf;
        drv(cur);
        hold_rand($urandom_range(5, 10));
      end else if (r == 7) begin
        drv(64'({$urandom, $urandom}));
        hold_rand($urandom_range(1, 2));
        drv(cur);
        hold_rand(7);
      end else begin
        nf = 64'({$urandom, $urandom});
        if (nf != cur) begin
          if (nf[63:16] == cur[47:0]) exp_q.push_back(mdl(nf[15:0]));
          else exp_err++;
        end
        cur = nf;
        drv(cur);
        hold_rand($urandom_range(5, 10));
      end
    end
    ch_ready = 1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    step();
    sb_on = 0;
    ch_ready = 0;
    chk("rand_drain", exp_q.size(), 0);
    chk("rand_level", fifo_level, 0);
    chk("rand_overflow", overflow, 0);
    chk("rand_err_count", err_cnt, exp_err);

    rst = 1;
    drv('1);
    repeat (2) step();
    rst = 0;
    cur = '1;
    foreach (known[i]) begin
      if (i == 3) continue;
      if (i == 10) break;
      cur = {cur[47:0], known[i]};
      drv(cur);
      repeat (6) step();
    end
    chk("bp_level", fifo_level, 8);
    chk("bp_overflow", overflow, 1);
    cur = {cur[47:0], 16'hCC3F};
    drv(cur);
    repeat (4) step();
    ch_ready = 1;
    step();
    ch_ready = 0;
    chk("full_push_pop_level", fifo_level, 8);
    begin
      logic [7:0] order[8] = '{"O", "Y", "a", "n", "d", "A", "P", "H"};
      ch_ready = 1;
      foreach (order[i]) begin
        chk("bp_order", {ch_unknown, ch_data}, {1'b0, order[i]});
        step();
      end
      ch_ready = 0;
    end
    chk("bp_empty", ch_valid, 0);
    chk("bp_overflow_sticky", overflow, 1);

    cur = {cur[47:0], 16'h00FF};
    drv(cur);
    repeat (2) step();
    rst = 1;
    step();
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_valid", ch_valid, 0);
    chk("mid_rst_data", {ch_unknown, ch_data}, 0);
    chk("mid_rst_err", shift_err, 0);
    drv('1);
    step();
    rst = 0;
    repeat (2) step();
    drv(64'hFFFF_FFFF_FFFF_CF00);
    repeat (5) step();
    chk("post_rst_char", {ch_unknown, ch_data}, 9'h043);
    chk("post_rst_level", fifo_level, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
